// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential instruction fetcher feeding a small FIFO of
// {instruction, PC} pairs for decode. It issues one ROM read per cycle while
// credit allows, and a redirect flushes everything and restarts at the target.
// Optional build macro IFQ_BYPASS_EN: a response arriving into an empty queue
// goes straight to INST, so the fetch-to-decode latency drops to one cycle.
module ifetch_queue #(
    parameter int SIZE       = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    output logic [ADDR_WIDTH-1:0] iaddr,
    output logic                  imem_req,
    input  logic [SIZE-1:0]       idata,
    input  logic                  REDIRECT,
    input  logic [ADDR_WIDTH-1:0] REDIRECT_PC,
    output logic [SIZE-1:0]       INST,
    output logic [ADDR_WIDTH-1:0] INST_PC,
    output logic                  INST_VALID,
    input  logic                  INST_READY
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PW:0]           occ_q, occ_d;
    logic                  infl_q, infl_d;
    logic [ADDR_WIDTH-1:0] infl_pc_q, infl_pc_d;
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [SIZE-1:0]       inst_mem_q [DEPTH];
    logic [SIZE-1:0]       inst_mem_d [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem_q   [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem_d   [DEPTH];

    logic q_nonempty;
    logic push;
    logic pop;
`ifdef IFQ_BYPASS_EN
    logic byp;
`endif

    // Output side: fetch request under credit, head or bypassed instruction.
    always_comb begin
        q_nonempty = (occ_q != '0);
        // Queued entries plus the one in flight can never exceed DEPTH, so
        // every response has a slot reserved before it is even requested.
        imem_req   = !RESET && !REDIRECT &&
                     ((occ_q + (PW+1)'(infl_q)) < DEPTH_C);
        iaddr      = RESET ? '0 : {2'b00, fetch_pc_q[ADDR_WIDTH-1:2]};
        INST       = '0;
        INST_PC    = '0;
        INST_VALID = !RESET && q_nonempty;
        if (!RESET && q_nonempty) begin
            INST    = inst_mem_q[head_q];
            INST_PC = pc_mem_q[head_q];
        end
`ifdef IFQ_BYPASS_EN
        // A response that lands on an empty queue is shown immediately; a
        // response landing in a redirect cycle is wrong-path and never shown.
        byp = !RESET && !REDIRECT && !q_nonempty && infl_q;
        if (byp) begin
            INST       = idata;
            INST_PC    = infl_pc_q;
            INST_VALID = 1'b1;
        end
        push = infl_q && !REDIRECT && !(byp && INST_READY);
`else
        push = infl_q && !REDIRECT;
`endif
        pop = q_nonempty && INST_VALID && INST_READY;
    end

    // Next-state: redirect flushes and reloads the PC, otherwise push/pop/fetch.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        occ_d      = occ_q;
        infl_d     = infl_q;
        infl_pc_d  = infl_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        inst_mem_d = inst_mem_q;
        pc_mem_d   = pc_mem_q;
        if (REDIRECT) begin
            // Masking keeps the fetch PC word aligned regardless of target.
            fetch_pc_d = REDIRECT_PC & ~ADDR_WIDTH'(3);
            occ_d      = '0;
            infl_d     = 1'b0;
            head_d     = '0;
            tail_d     = '0;
        end else begin
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            if (push) begin
                inst_mem_d[tail_q] = idata;
                pc_mem_d[tail_q]   = infl_pc_q;
                tail_d             = tail_q + 1'b1;
            end
            occ_d     = occ_q + (PW+1)'(push) - (PW+1)'(pop);
            infl_d    = imem_req;
            infl_pc_d = fetch_pc_q;
            if (imem_req) begin
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
            end
        end
    end

    // Control state with synchronous active-high reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_pc_q <= '0;
            occ_q      <= '0;
            infl_q     <= 1'b0;
            infl_pc_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            occ_q      <= occ_d;
            infl_q     <= infl_d;
            infl_pc_q  <= infl_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Entry storage; contents are only visible through a valid head, so no reset.
    always_ff @(posedge CLK) begin
        inst_mem_q <= inst_mem_d;
        pc_mem_q   <= pc_mem_d;
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: a ROM answering one cycle after each request
// (word n = 0x13 + n), a queue-level reference model checked every cycle,
// and directed scenarios with hand-computed literal expectations.
module tb_ifetch_queue;
    localparam int SIZE = 32;
    localparam int AW   = 10;
    localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          REDIRECT = 1'b0;
    logic [AW-1:0] REDIRECT_PC = '0;
    logic          INST_READY = 1'b1;
    logic [SIZE-1:0] idata = 32'hDEADBEEF;
    logic [AW-1:0] iaddr;
    logic          imem_req;
    logic [SIZE-1:0] INST;
    logic [AW-1:0] INST_PC;
    logic          INST_VALID;

    int vectors = 0;
    int errors  = 0;

    always #5 CLK = ~CLK;

    ifetch_queue #(.SIZE(SIZE), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET), .iaddr(iaddr), .imem_req(imem_req),
        .idata(idata), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
        .INST(INST), .INST_PC(INST_PC), .INST_VALID(INST_VALID),
        .INST_READY(INST_READY)
    );

    // Instruction ROM: data for a request appears one cycle later, junk otherwise.
    always @(posedge CLK) idata <= imem_req ? 32'h13 + 32'(iaddr) : 32'hDEADBEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: fetch PC, list of queued PCs, one inflight slot.
    int m_pc = 0;
    int mq[$];
    bit m_infl = 0;
    int m_infl_pc = 0;

    typedef struct {
        bit req;
        int iaddr;
        bit valid;
        bit byp;
        int pc;
        int inst;
    } exp_t;

    function automatic exp_t model_out();
        exp_t e;
        e.req   = !RESET && !REDIRECT && (mq.size() + int'(m_infl) < DEPTH);
        e.iaddr = RESET ? 0 : (m_pc >> 2);
        e.byp   = 1'b0;
`ifdef IFQ_BYPASS_EN
        e.byp   = !RESET && !REDIRECT && mq.size() == 0 && m_infl;
`endif
        e.valid = !RESET && (mq.size() > 0 || e.byp);
        e.pc    = (mq.size() > 0) ? mq[0] : m_infl_pc;
        e.inst  = 32'h13 + (e.pc >> 2);
        return e;
    endfunction

    logic          s_valid, s_req;
    logic [31:0]   s_inst;
    logic [AW-1:0] s_pc, s_iaddr;

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge CLK) begin
        exp_t e;
        e = model_out();
        s_valid = INST_VALID; s_req = imem_req; s_iaddr = iaddr;
        s_inst = INST; s_pc = INST_PC;
        chk("model_valid", 32'(INST_VALID), 32'(e.valid));
        chk("model_req", 32'(imem_req), 32'(e.req));
        chk("model_iaddr", 32'(iaddr), e.iaddr);
        if (e.valid) begin
            chk("model_inst", INST, e.inst);
            chk("model_pc", 32'(INST_PC), e.pc);
        end
    end

    // Model state update at the clock edge, using the inputs of that cycle.
    always @(posedge CLK) begin
        exp_t e;
        e = model_out();
        if (RESET) begin
            mq.delete(); m_infl = 0; m_pc = 0; m_infl_pc = 0;
        end else if (REDIRECT) begin
            mq.delete(); m_infl = 0; m_pc = int'(REDIRECT_PC) & ~3;
        end else begin
            if (e.valid && INST_READY && !e.byp) void'(mq.pop_front());
            if (m_infl && !(e.byp && INST_READY)) mq.push_back(m_infl_pc);
            m_infl = e.req;
            m_infl_pc = m_pc;
            if (e.req) m_pc = (m_pc + 4) % (1 << AW);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic flush_to(input int pc);
        REDIRECT = 1'b1; REDIRECT_PC = AW'(pc);
        tick();
        REDIRECT = 1'b0;
    endtask

    initial begin
        int first, nreq, p0;
        int pcs[$];
        int exp_ia[3] = '{32'h0FE, 32'h0FF, 32'h000};
        int exp_wp[3] = '{32'h3F8, 32'h3FC, 32'h000};
        int exp_dp[4] = '{32'h000, 32'h004, 32'h008, 32'h00C};
        bit [15:0] pat = 16'b1011_0010_1110_0101;

        // Reset state.
        tick(); tick();
        chk("rst_valid", 32'(s_valid), 0);
        chk("rst_req", 32'(s_req), 0);
        chk("rst_iaddr", 32'(s_iaddr), 0);
        chk("rst_inst", s_inst, 0);
        chk("rst_pc", 32'(s_pc), 0);

        // Streaming from reset: iaddr 0,1,2,...; first instruction after LAT cycles.
        RESET = 1'b0; INST_READY = 1'b1;
        first = -1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("stream_iaddr", 32'(s_iaddr), c);
            chk("stream_req", 32'(s_req), 1);
            if (s_valid && first < 0) begin
                first = c;
                chk("first_inst", s_inst, 32'h13);
                chk("first_pc", 32'(s_pc), 0);
            end
        end
        chk("first_valid_cycle", first, LAT);

        // Back-pressure: exactly DEPTH requests, then drain in order.
        flush_to(0);
        INST_READY = 1'b0;
        nreq = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (s_req) nreq++;
        end
        chk("bp_req_count", nreq, DEPTH);
        chk("bp_req_stalled", 32'(s_req), 0);
        INST_READY = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("drain_valid", 32'(s_valid), 1);
            chk("drain_pc", 32'(s_pc), exp_dp[c]);
        end

        // Full queue, one-cycle accept: head advances by one entry.
        INST_READY = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        INST_READY = 1'b1;
        tick();
        p0 = int'(s_pc);
        INST_READY = 1'b0;
        tick();
        chk("single_pop_valid", 32'(s_valid), 1);
        chk("single_pop_pc", 32'(s_pc), (p0 + 4) % (1 << AW));

        // Redirect with 3 queued + 1 inflight.
        flush_to(0);
        INST_READY = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        REDIRECT = 1'b1; REDIRECT_PC = AW'(32'h123);
        tick();
        chk("redir_cycle_req", 32'(s_req), 0);
        REDIRECT = 1'b0; INST_READY = 1'b1;
        tick();
        chk("redir_next_valid", 32'(s_valid), 0);
        chk("redir_next_req", 32'(s_req), 1);
        chk("redir_iaddr", 32'(s_iaddr), 32'h048);
        first = -1;
        for (int c = 0; c < 4 && first < 0; c++) begin
            tick();
            if (s_valid) begin
                first = c;
                chk("redir_pc", 32'(s_pc), 32'h120);
                chk("redir_inst", s_inst, 32'h13 + 32'h48);
            end
        end
        chk("redir_valid_seen", 32'(first >= 0), 1);

        // PC wrap at the top of the address space.
        flush_to(32'h3F8);
        pcs.delete();
        for (int c = 0; c < 8; c++) begin
            tick();
            if (c < 3) chk("wrap_iaddr", 32'(s_iaddr), exp_ia[c]);
            if (s_valid) pcs.push_back(int'(s_pc));
        end
        chk("wrap_count", 32'(pcs.size() >= 3), 1);
        for (int i = 0; i < 3 && i < pcs.size(); i++) chk("wrap_pc", pcs[i], exp_wp[i]);

        // Mid-stream reset with 2 queued + 1 inflight.
        flush_to(0);
        INST_READY = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        RESET = 1'b1;
        tick();
        chk("mrst_valid", 32'(s_valid), 0);
        chk("mrst_req", 32'(s_req), 0);
        RESET = 1'b0; INST_READY = 1'b1;
        tick();
        chk("mrst_next_valid", 32'(s_valid), 0);
        chk("mrst_next_req", 32'(s_req), 1);
        chk("mrst_iaddr", 32'(s_iaddr), 0);
        first = -1;
        for (int c = 0; c < 4 && first < 0; c++) begin
            tick();
            if (s_valid) begin
                first = c;
                chk("mrst_first_pc", 32'(s_pc), 0);
            end
        end
        chk("mrst_valid_seen", 32'(first >= 0), 1);

        // Irregular ready pattern with a redirect in the middle; model checks.
        for (int i = 0; i < 16; i++) begin
            INST_READY = pat[i];
            if (i == 9) begin
                REDIRECT = 1'b1; REDIRECT_PC = AW'(32'h0AE);
            end
            tick();
            REDIRECT = 1'b0;
        end
        INST_READY = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
